// File: rtl/axis_param_scheduler.sv
// Round-robin scheduler that time-shares one parameter calculator
// among NAXES axis channels and banks each axis's latest result.
module axis_param_scheduler #(
  parameter int NAXES    = 4,
  parameter int CALC_LAT = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NAXES-1:0]             req,
  input  logic [NAXES-1:0][31:0]       axis_steps,
  output logic [4:0][31:0]             calc_params,
  output logic                         calc_start,
  input  logic [4:0][31:0]             calc_new_par,
  output logic [NAXES-1:0][4:0][31:0]  axis_par,
  output logic [NAXES-1:0]             axis_valid,
  output logic                         busy,
  output logic                         done
);

  localparam int PW = (NAXES > 1) ? $clog2(NAXES) : 1;
  localparam int WW = (CALC_LAT > 0) ? $clog2(CALC_LAT + 1) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] STORE = 2'd3;

  logic [1:0]                     state_q, state_d;
  logic [NAXES-1:0]               pending_q, pending_d;
  logic [PW-1:0]                  rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]                  sel_q, sel_d;
  logic [WW-1:0]                  wait_q, wait_d;
  logic [NAXES-1:0][31:0]         steps_q, steps_d;
  logic [NAXES-1:0][4:0][31:0]    par_q, par_d;
  logic [NAXES-1:0]               valid_q, valid_d;
  logic [31:0]                    n_q, n_d;
  logic                           done_q, done_d;

  logic [PW-1:0] nxt_ptr;
  logic [PW-1:0] arb_start;
  logic [PW-1:0] arb_idx;
  logic          arb_found;
  logic [31:0]   sel_steps;

  assign nxt_ptr   = (sel_q == PW'(NAXES - 1)) ? '0 : sel_q + PW'(1);
  assign arb_start = (state_q == STORE) ? nxt_ptr : rr_ptr_q;

  always_comb begin
    int j;
    j         = 0;
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = 0; k < NAXES; k++) begin
      j = int'(arb_start) + k;
      if (j >= NAXES) j = j - NAXES;
      if (!arb_found && pending_q[j]) begin
        arb_found = 1'b1;
        arb_idx   = PW'(j);
      end
    end
  end

  // A request landing in the arbitration cycle must reach the calculator
  assign sel_steps = req[arb_idx] ? axis_steps[arb_idx]
                                  : steps_q[arb_idx];

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    rr_ptr_d  = rr_ptr_q;
    sel_d     = sel_q;
    wait_d    = wait_q;
    steps_d   = steps_q;
    par_d     = par_q;
    valid_d   = valid_q;
    n_d       = n_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arb_found) begin
          sel_d   = arb_idx;
          n_d     = sel_steps;
          state_d = LOAD;
        end
      end
      LOAD: begin
        pending_d[sel_q] = 1'b0;
        wait_d           = WW'(CALC_LAT - 1);
        state_d          = WAIT;
      end
      WAIT: begin
        if (wait_q == '0) state_d = STORE;
        else              wait_d  = wait_q - WW'(1);
      end
      STORE: begin
        if (!pending_q[sel_q]) begin
          par_d[sel_q]   = calc_new_par;
          valid_d[sel_q] = 1'b1;
        end
        rr_ptr_d = nxt_ptr;
        if (arb_found) begin
          sel_d   = arb_idx;
          n_d     = sel_steps;
          state_d = LOAD;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // New requests override any clear or store decided above
    for (int i = 0; i < NAXES; i++) begin
      if (req[i]) begin
        steps_d[i]   = axis_steps[i];
        pending_d[i] = 1'b1;
        valid_d[i]   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      rr_ptr_q  <= '0;
      sel_q     <= '0;
      wait_q    <= '0;
      steps_q   <= '0;
      par_q     <= '0;
      valid_q   <= '0;
      n_q       <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rr_ptr_q  <= rr_ptr_d;
      sel_q     <= sel_d;
      wait_q    <= wait_d;
      steps_q   <= steps_d;
      par_q     <= par_d;
      valid_q   <= valid_d;
      n_q       <= n_d;
      done_q    <= done_d;
    end
  end

  assign calc_params[0]   = n_q;
  assign calc_params[4:1] = '0;
  assign calc_start       = (state_q == LOAD);
  assign axis_par         = par_q;
  assign axis_valid       = valid_q;
  assign busy             = (state_q != IDLE);
  assign done             = done_q;

endmodule

// File: tb/tb_axis_param_scheduler.sv
// Directed and randomized bench for axis_param_scheduler with a
// behavioural calculator stand-in and an expected-result model.
module tb_axis_param_scheduler;

  localparam int NAXES    = 4;
  localparam int CALC_LAT = 2;

  logic                         clk;
  logic                         reset;
  logic [NAXES-1:0]             req;
  logic [NAXES-1:0][31:0]       axis_steps;
  logic [4:0][31:0]             calc_params;
  logic                         calc_start;
  logic [4:0][31:0]             calc_new_par;
  logic [NAXES-1:0][4:0][31:0]  axis_par;
  logic [NAXES-1:0]             axis_valid;
  logic                         busy;
  logic                         done;

  axis_param_scheduler #(.NAXES(NAXES), .CALC_LAT(CALC_LAT)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .axis_steps   (axis_steps),
    .calc_params  (calc_params),
    .calc_start   (calc_start),
    .calc_new_par (calc_new_par),
    .axis_par     (axis_par),
    .axis_valid   (axis_valid),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0][31:0] calc_model(input logic [31:0] n);
    logic [4:0][31:0] p;
    p[0] = n;
    p[1] = n * n;
    p[2] = n * 32'd3;
    p[3] = n + (n >> 1);
    p[4] = n ^ (n << 1);
    return p;
  endfunction

  // Calculator stand-in: result appears CALC_LAT edges after params
  logic [4:0][31:0] pipe [CALC_LAT];
  always @(posedge clk) begin
    pipe[0] <= calc_model(calc_params[0]);
    for (int k = 1; k < CALC_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign calc_new_par = pipe[CALC_LAT-1];

  int total = 0;
  int bad   = 0;
  int starts[$];
  int done_cnt;

  task automatic chk(input string tag, input logic [159:0] obs,
                     input logic [159:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic collect(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      tick();
      if (calc_start) starts.push_back(int'(calc_params[0]));
      if (done) done_cnt++;
    end
  endtask

  task automatic clr();
    starts   = {};
    done_cnt = 0;
  endtask

  task automatic chk_starts(input string tag, input int exp[$]);
    chk({tag, "_njobs"}, 160'(starts.size()), 160'(exp.size()));
    for (int k = 0; k < exp.size(); k++)
      chk($sformatf("%s_job%0d", tag, k),
          (k < starts.size()) ? 160'(starts[k]) : '1, 160'(exp[k]));
  endtask

  task automatic do_reset();
    req   = '0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  logic [31:0]      latest [NAXES];
  int               req_at [NAXES];
  int               jobs_at[NAXES];
  logic [NAXES-1:0] waiting;
  logic [4:0][31:0] prev_params;
  int               jobs;
  bit               got_done;

  initial begin
    reset      = 1'b0;
    req        = '0;
    axis_steps = '0;
    clr();
    do_reset();

    // reset state
    chk("rst_busy", 160'(busy), 160'(0));
    chk("rst_done", 160'(done), 160'(0));
    chk("rst_start", 160'(calc_start), 160'(0));
    chk("rst_params", 160'(calc_params), 160'(0));
    chk("rst_valid", 160'(axis_valid), 160'(0));
    chk("rst_par", 160'(axis_par[0]) | 160'(axis_par[3]), 160'(0));

    // single request latency
    req[0] = 1'b1;
    axis_steps[0] = 32'd100;
    tick();
    req = '0;
    chk("t1_c1_busy", 160'(busy), 160'(0));
    tick();
    chk("t1_c2_start", 160'(calc_start), 160'(1));
    chk("t1_c2_n", 160'(calc_params[0]), 160'(100));
    chk("t1_c2_busy", 160'(busy), 160'(1));
    tick();
    chk("t1_c3_start", 160'(calc_start), 160'(0));
    tick();
    tick();
    chk("t1_c5_valid", 160'(axis_valid), 160'(0));
    chk("t1_c5_done", 160'(done), 160'(0));
    tick();
    chk("t1_c6_valid", 160'(axis_valid), 160'(4'b0001));
    chk("t1_c6_par", 160'(axis_par[0]), 160'(calc_model(32'd100)));
    chk("t1_c6_done", 160'(done), 160'(1));
    chk("t1_c6_busy", 160'(busy), 160'(0));
    tick();
    chk("t1_c7_done", 160'(done), 160'(0));

    // simultaneous requests on all axes
    do_reset();
    clr();
    req = 4'b1111;
    axis_steps[0] = 32'd5;
    axis_steps[1] = 32'd1;
    axis_steps[2] = 32'd2;
    axis_steps[3] = 32'd0;
    collect(1);
    req = '0;
    collect(30);
    chk_starts("t2", '{5, 1, 2, 0});
    chk("t2_done", 160'(done_cnt), 160'(1));
    chk("t2_valid", 160'(axis_valid), 160'(4'b1111));
    chk("t2_par0", 160'(axis_par[0]), 160'(calc_model(32'd5)));
    chk("t2_par1", 160'(axis_par[1]), 160'(calc_model(32'd1)));
    chk("t2_par2", 160'(axis_par[2]), 160'(calc_model(32'd2)));
    chk("t2_par3", 160'(axis_par[3]), 160'(0));

    // arrival while axis 2 is in flight: lone pending axis is next
    do_reset();
    clr();
    req[2] = 1'b1;
    axis_steps[2] = 32'd7;
    collect(1);
    req = '0;
    collect(2);
    req[1] = 1'b1;
    axis_steps[1] = 32'd11;
    collect(1);
    req = '0;
    collect(20);
    chk_starts("t3a", '{7, 11});

    // axes 0 and 3 pending after axis 2: pointer order gives 3 then 0
    do_reset();
    clr();
    req[2] = 1'b1;
    axis_steps[2] = 32'd7;
    collect(1);
    req = '0;
    collect(2);
    req[0] = 1'b1;
    req[3] = 1'b1;
    axis_steps[0] = 32'd8;
    axis_steps[3] = 32'd9;
    collect(1);
    req = '0;
    collect(25);
    chk_starts("t3b", '{7, 9, 8});
    chk("t3b_done", 160'(done_cnt), 160'(1));

    // re-request during WAIT discards the stale result
    do_reset();
    clr();
    req[1] = 1'b1;
    axis_steps[1] = 32'd10;
    collect(1);
    req = '0;
    collect(2);
    req[1] = 1'b1;
    axis_steps[1] = 32'd20;
    collect(1);
    req = '0;
    collect(2);
    chk("t4_stale_valid", 160'(axis_valid[1]), 160'(0));
    chk("t4_stale_par", 160'(axis_par[1]), 160'(0));
    collect(20);
    chk_starts("t4", '{10, 20});
    chk("t4_done", 160'(done_cnt), 160'(1));
    chk("t4_valid", 160'(axis_valid[1]), 160'(1));
    chk("t4_par", 160'(axis_par[1]), 160'(calc_model(32'd20)));

    // async reset in the middle of a job
    clr();
    req[0] = 1'b1;
    axis_steps[0] = 32'd33;
    collect(1);
    req = '0;
    collect(2);
    chk("t5_pre_busy", 160'(busy), 160'(1));
    reset = 1'b0;
    #1;
    chk("t5_busy", 160'(busy), 160'(0));
    chk("t5_start", 160'(calc_start), 160'(0));
    chk("t5_params", 160'(calc_params), 160'(0));
    chk("t5_valid", 160'(axis_valid), 160'(0));
    chk("t5_par1", 160'(axis_par[1]), 160'(0));
    chk("t5_done", 160'(done), 160'(0));
    tick();
    tick();
    reset = 1'b1;
    clr();
    collect(20);
    chk("t5_no_resume", 160'(starts.size()), 160'(0));
    chk("t5_idle", 160'(busy), 160'(0));

    // randomized: axis 0 hammered, others request once each
    for (int i = 0; i < NAXES; i++) begin
      latest[i] = '0;
      req_at[i] = (i == 0) ? -1 : int'($urandom_range(0, 50));
      jobs_at[i] = 0;
    end
    waiting     = '0;
    jobs        = 0;
    prev_params = calc_params;
    for (int cyc = 0; cyc <= 50; cyc++) begin
      req = '0;
      if (cyc % 2 == 0) begin
        latest[0]     = $urandom;
        req[0]        = 1'b1;
        axis_steps[0] = latest[0];
      end
      for (int i = 1; i < NAXES; i++) begin
        if (cyc == req_at[i]) begin
          latest[i]     = $urandom;
          req[i]        = 1'b1;
          axis_steps[i] = latest[i];
          waiting[i]    = 1'b1;
          jobs_at[i]    = jobs;
        end
      end
      tick();
      if (calc_start) jobs++;
      if (busy && !calc_start)
        chk("t6_params_stable", 160'(calc_params), 160'(prev_params));
      prev_params = calc_params;
      for (int i = 1; i < NAXES; i++) begin
        if (waiting[i] && axis_valid[i]) begin
          waiting[i] = 1'b0;
          chk($sformatf("t6_fair%0d", i),
              160'(jobs - jobs_at[i] <= NAXES), 160'(1));
        end
      end
    end
    req = '0;
    got_done = 1'b0;
    for (int c = 0; c < 100 && !got_done; c++) begin
      tick();
      if (calc_start) jobs++;
      for (int i = 1; i < NAXES; i++) begin
        if (waiting[i] && axis_valid[i]) begin
          waiting[i] = 1'b0;
          chk($sformatf("t6_fair%0d", i),
              160'(jobs - jobs_at[i] <= NAXES), 160'(1));
        end
      end
      if (done) got_done = 1'b1;
    end
    chk("t6_drained", 160'(got_done), 160'(1));
    chk("t6_waiting", 160'(waiting), 160'(0));
    chk("t6_valid", 160'(axis_valid), 160'(4'b1111));
    for (int i = 0; i < NAXES; i++)
      chk($sformatf("t6_par%0d", i), 160'(axis_par[i]),
          160'(calc_model(latest[i])));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
